seq_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end of the serial 9-bit pattern link.
- Accepts a PAY_W-bit payload over a valid/ready handshake.
- Wraps the payload as {HEAD, payload, TAIL} and shifts it out MSB-first, one bit per clk, on output a.
- Drives the serial input of the downstream sequence detector. With defaults, each frame is 011_ppp_110, which that detector flags.

---
 rtl/seq_frame_tx.sv | 118 +++++++++++
 tb/tb_seq_frame_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: wraps each accepted payload as {HEAD, payload, TAIL}
// and shifts it out MSB-first on a, one bit per clock.
module seq_frame_tx #(
    parameter logic [2:0]  HEAD     = 3'b011,
    parameter logic [2:0]  TAIL     = 3'b110,
    parameter int unsigned PAY_W    = 3,
    parameter int unsigned GAP      = 0,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAY_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             a,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned N  = PAY_W + 6;
    localparam int unsigned CW = $clog2(N + GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [PAY_W-1:0] hold;
    logic             hold_full;
    logic [N-1:0]     sr;
    logic [CW-1:0]    count;

    logic accept_c;
    logic slot_c;
    logic load_c;
    logic hold_full_nxt_c;
    logic idle_nxt_c;

    assign din_ready = !hold_full && !rst;
    assign accept_c  = din_valid && din_ready;

    // A slot is an edge at which a new frame may begin if a payload is waiting.
    assign slot_c = (state == ST_IDLE)
                 || (state == ST_GAP && count == '0)
                 || (state == ST_SHIFT && count == '0 && GAP == 0);
    assign load_c          = slot_c && hold_full;
    assign hold_full_nxt_c = !flush && (accept_c || (hold_full && !load_c));
    assign idle_nxt_c      = flush || (slot_c && !hold_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold        <= '0;
            hold_full   <= 1'b0;
            sr          <= '0;
            count       <= '0;
            a           <= IDLE_LVL;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            hold_full   <= hold_full_nxt_c;
            busy        <= !idle_nxt_c || hold_full_nxt_c;
            if (accept_c && !flush) begin
                hold <= din;
            end
            if (flush) begin
                state <= ST_IDLE;
                count <= '0;
                a     <= IDLE_LVL;
            end else if (load_c) begin
                sr          <= {HEAD, hold, TAIL};
                a           <= HEAD[2];
                frame_start <= 1'b1;
                state       <= ST_SHIFT;
                count       <= CW'(N - 1);
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (count != '0) begin
                            // sr[N-1] is already on a; present the next bit down.
                            a          <= sr[N-2];
                            sr         <= sr << 1;
                            count      <= count - CW'(1);
                            frame_done <= (count == CW'(1));
                        end else if (GAP > 0) begin
                            state <= ST_GAP;
                            count <= CW'(GAP - 1);
                            a     <= IDLE_LVL;
                        end else begin
                            state <= ST_IDLE;
                            a     <= IDLE_LVL;
                        end
                    end
                    ST_GAP: begin
                        a <= IDLE_LVL;
                        if (count != '0) begin
                            count <= count - CW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        a     <= IDLE_LVL;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: default, GAP=2 and wide/idle-high instances, with a
// queue of expected serial bits filled as payloads are offered.
module tb_seq_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [2:0] d_din;
    logic       d_valid, d_ready, d_flush, d_a, d_fs, d_fd, d_busy;
    logic [2:0] g_din;
    logic       g_valid, g_ready, g_flush, g_a, g_fs, g_fd, g_busy;
    logic [4:0] w_din;
    logic       w_valid, w_ready, w_flush, w_a, w_fs, w_fd, w_busy;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic e;

    seq_frame_tx u_dut (
        .clk(clk), .rst(rst), .din(d_din), .din_valid(d_valid), .din_ready(d_ready),
        .flush(d_flush), .a(d_a), .frame_start(d_fs), .frame_done(d_fd), .busy(d_busy)
    );

    seq_frame_tx #(.GAP(2)) u_gap (
        .clk(clk), .rst(rst), .din(g_din), .din_valid(g_valid), .din_ready(g_ready),
        .flush(g_flush), .a(g_a), .frame_start(g_fs), .frame_done(g_fd), .busy(g_busy)
    );

    seq_frame_tx #(.PAY_W(5), .IDLE_LVL(1'b1)) u_wide (
        .clk(clk), .rst(rst), .din(w_din), .din_valid(w_valid), .din_ready(w_ready),
        .flush(w_flush), .a(w_a), .frame_start(w_fs), .frame_done(w_fd), .busy(w_busy)
    );

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (d_a !== 1'b0)     begin errors++; $display("FAIL reset_a got %b want 0", d_a); end
        checks++; if (d_fs !== 1'b0)    begin errors++; $display("FAIL reset_fs got %b want 0", d_fs); end
        checks++; if (d_fd !== 1'b0)    begin errors++; $display("FAIL reset_fd got %b want 0", d_fd); end
        checks++; if (d_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", d_busy); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", d_ready); end
        checks++; if (w_a !== 1'b1)     begin errors++; $display("FAIL reset_wide_a got %b want 1", w_a); end
        rst = 1'b0;
        #1;
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", d_ready); end
        checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL release_gap_ready got %b want 1", g_ready); end
    endtask

    task automatic test_single(input logic [2:0] p);
        logic [8:0] f;
        f = {3'b011, p, 3'b110};
        @(posedge clk); #1;
        d_din = p; d_valid = 1'b1;
        for (int b = 8; b >= 0; b--) exp_q.push_back(f[b]);
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        d_valid = 1'b0;
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b want 0", d_ready); end
        checks++; if (d_busy !== 1'b1)  begin errors++; $display("FAIL single_busy got %b want 1", d_busy); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (d_a !== e) begin errors++; $display("FAIL single_bit%0d got %b want %b", i, d_a, e); end
            checks++; if (d_fs !== 1'(i == 0)) begin errors++; $display("FAIL single_fs%0d got %b want %b", i, d_fs, 1'(i == 0)); end
            checks++; if (d_fd !== 1'(i == 8)) begin errors++; $display("FAIL single_fd%0d got %b want %b", i, d_fd, 1'(i == 8)); end
        end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", d_busy); end
    endtask

    task automatic test_back_to_back;
        logic [17:0] f;
        logic        rdy;
        f = {3'b011, 3'b000, 3'b110, 3'b011, 3'b111, 3'b110};
        @(posedge clk); #1;
        d_din = 3'b000; d_valid = 1'b1;
        for (int b = 17; b >= 0; b--) exp_q.push_back(f[b]);
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_acc got %b want 0", d_ready); end
        d_din = 3'b111;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            if (i == 1) d_valid = 1'b0;
            e   = exp_q.pop_front();
            rdy = (i == 0) || (i >= 9);
            checks++; if (d_a !== e) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i, d_a, e); end
            checks++; if (d_ready !== rdy) begin errors++; $display("FAIL b2b_ready%0d got %b want %b", i, d_ready, rdy); end
            checks++; if (d_fs !== 1'(i == 0 || i == 9)) begin errors++; $display("FAIL b2b_fs%0d got %b", i, d_fs); end
            checks++; if (d_fd !== 1'(i == 8 || i == 17)) begin errors++; $display("FAIL b2b_fd%0d got %b", i, d_fd); end
        end
    endtask

    task automatic test_gap;
        logic [8:0] f1, f2;
        f1 = {3'b011, 3'b001, 3'b110};
        f2 = {3'b011, 3'b010, 3'b110};
        @(posedge clk); #1;
        g_din = 3'b001; g_valid = 1'b1;
        for (int b = 8; b >= 0; b--) exp_q.push_back(f1[b]);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        for (int b = 8; b >= 0; b--) exp_q.push_back(f2[b]);
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b0);
        @(posedge clk); #1;
        g_din = 3'b010;
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            if (i == 1) g_valid = 1'b0;
            e = exp_q.pop_front();
            checks++; if (g_a !== e) begin errors++; $display("FAIL gap_bit%0d got %b want %b", i, g_a, e); end
            checks++; if (g_busy !== 1'(i < 22)) begin errors++; $display("FAIL gap_busy%0d got %b want %b", i, g_busy, 1'(i < 22)); end
            checks++; if (g_fs !== 1'(i == 0 || i == 11)) begin errors++; $display("FAIL gap_fs%0d got %b", i, g_fs); end
            checks++; if (g_fd !== 1'(i == 8 || i == 19)) begin errors++; $display("FAIL gap_fd%0d got %b", i, g_fd); end
        end
    endtask

    task automatic test_flush;
        logic [8:0] f;
        f = {3'b011, 3'b100, 3'b110};
        @(posedge clk); #1;
        d_din = 3'b100; d_valid = 1'b1;
        for (int b = 8; b >= 5; b--) exp_q.push_back(f[b]);
        @(posedge clk); #1;
        d_din = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) d_valid = 1'b0;
            e = exp_q.pop_front();
            checks++; if (d_a !== e) begin errors++; $display("FAIL flush_pre%0d got %b want %b", i, d_a, e); end
        end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL flush_holdfull got %b want 0", d_ready); end
        d_flush = 1'b1; d_valid = 1'b1; d_din = 3'b111;
        @(posedge clk); #1;
        d_flush = 1'b0; d_valid = 1'b0;
        checks++; if (d_a !== 1'b0)     begin errors++; $display("FAIL flush_a got %b want 0", d_a); end
        checks++; if (d_busy !== 1'b0)  begin errors++; $display("FAIL flush_busy got %b want 0", d_busy); end
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", d_ready); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++; if (d_a !== 1'b0 || d_fs !== 1'b0 || d_busy !== 1'b0) begin
                errors++; $display("FAIL flush_quiet%0d got a=%b fs=%b busy=%b want 0", i, d_a, d_fs, d_busy);
            end
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        d_din = 3'b010; d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (d_a !== 1'b1) begin errors++; $display("FAIL arst_mid_a got %b want 1", d_a); end
        #1 rst = 1'b1;
        #1;
        checks++; if (d_a !== 1'b0)     begin errors++; $display("FAIL arst_a got %b want 0", d_a); end
        checks++; if (d_fs !== 1'b0 || d_fd !== 1'b0) begin errors++; $display("FAIL arst_flags got %b%b want 00", d_fs, d_fd); end
        checks++; if (d_busy !== 1'b0)  begin errors++; $display("FAIL arst_busy got %b want 0", d_busy); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got %b want 0", d_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL arst_release_ready got %b want 1", d_ready); end
        test_single(3'b110);
    endtask

    task automatic test_wide;
        logic [10:0] f;
        f = {3'b011, 5'b10011, 3'b110};
        @(posedge clk); #1;
        checks++; if (w_a !== 1'b1) begin errors++; $display("FAIL wide_idle got %b want 1", w_a); end
        w_din = 5'b10011; w_valid = 1'b1;
        for (int b = 10; b >= 0; b--) exp_q.push_back(f[b]);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        @(posedge clk); #1;
        w_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (w_a !== e) begin errors++; $display("FAIL wide_bit%0d got %b want %b", i, w_a, e); end
            checks++; if (w_fs !== 1'(i == 0))  begin errors++; $display("FAIL wide_fs%0d got %b", i, w_fs); end
            checks++; if (w_fd !== 1'(i == 10)) begin errors++; $display("FAIL wide_fd%0d got %b", i, w_fd); end
        end
    endtask

    initial begin
        rst = 1'b1;
        d_din = '0; d_valid = 1'b0; d_flush = 1'b0;
        g_din = '0; g_valid = 1'b0; g_flush = 1'b0;
        w_din = '0; w_valid = 1'b0; w_flush = 1'b0;
        test_reset();
        test_single(3'b101);
        test_back_to_back();
        test_gap();
        test_flush();
        test_async_reset();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
